mode_select_ctrl: RTL

//  Front-panel input side of the mode display: debounces four raw push-buttons and runs
//  the mode/song selection FSM whose registered outputs (state, song) drive the tube

---
 rtl/mode_select_ctrl_pkg.sv | 46 ++++
 rtl/mode_select_ctrl_debounce.sv | 63 ++++++
 rtl/mode_select_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mode_select_ctrl_pkg.sv
// mode_select_ctrl_pkg: shared widths, mode/song codes, key indices and cursor stepping.
// Revision 1.0
`default_nettype none

package mode_select_ctrl_pkg;

  localparam int STATE_BITS = 3;
  localparam int SONG_BITS  = 1;
  localparam int NUM_KEYS   = 4;

  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_OK   = 2;
  localparam int KEY_BACK = 3;

  typedef enum logic [STATE_BITS-1:0] {
    MENU_MODE = 3'd0,
    FREE_MODE = 3'd1,
    AUTO_MODE = 3'd2,
    STDY_MODE = 3'd3,
    PLAY_MODE = 3'd4,
    SET_MODE  = 3'd5
  } mode_e;

  typedef enum logic [SONG_BITS-1:0] {
    LITTLE_STAR = 1'b0,
    TWO_TIGERS  = 1'b1
  } song_e;

  // Cursor walks the five non-menu modes as a ring: free..set.
  function automatic logic [STATE_BITS-1:0] cursor_step(
    input logic [STATE_BITS-1:0] cur,
    input logic                  fwd
  );
    logic [STATE_BITS-1:0] nxt;
    if (fwd) begin
      nxt = (cur == SET_MODE) ? FREE_MODE : cur + 3'd1;
    end else begin
      nxt = (cur == FREE_MODE) ? SET_MODE : cur - 3'd1;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mode_select_ctrl_debounce.sv
// key_debounce: 2-FF synchroniser, level debouncer and single press pulse for one raw button.
// Revision 1.0
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_meta;
  logic             r_sync;
  logic [1:0]       r_vld;
  logic             r_armed;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             w_diff;
  logic             w_accept;

  assign w_diff    = (r_sync != r_stable);
  assign w_accept  = w_diff && (r_cnt == CNT_LAST);
  assign key_pulse = r_pulse;

  // r_armed stays low until the synchroniser has shown a released key,
  // so a button held through reset cannot fire on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_vld    <= 2'b00;
      r_armed  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta <= key_raw;
      r_sync <= r_meta;
      r_vld  <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync) begin
        r_armed <= 1'b1;
      end
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_pulse <= w_accept && r_sync && r_armed;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_select_ctrl.sv
// mode_select_ctrl: debounced front-panel keys driving the mode/song selection FSM.
// Revision 1.0 -- optional idle auto-return to menu built when IDLE_TIMEOUT_EN is defined.
`default_nettype none

module mode_select_ctrl
  import mode_select_ctrl_pkg::*;
#(
  parameter int          DEBOUNCE_CYC = 2_000_000,
  parameter logic [31:0] IDLE_CYC     = 32'd3_000_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  key_ok,
  input  logic                  key_back,
  input  logic                  busy,
  output logic [STATE_BITS-1:0] state,
  output logic [STATE_BITS-1:0] cursor,
  output logic [SONG_BITS-1:0]  song,
  output logic                  mode_chg,
  output logic                  song_chg
);

  logic [NUM_KEYS-1:0]   w_key_raw;
  logic [NUM_KEYS-1:0]   w_pulse;
  logic                  w_up;
  logic                  w_down;
  logic                  w_ok;
  logic                  w_back;
  logic                  w_timeout;

  mode_e                 r_state;
  logic [STATE_BITS-1:0] r_cursor;
  song_e                 r_song;
  logic                  r_mode_chg;
  logic                  r_song_chg;
  mode_e                 w_state_nxt;
  logic [STATE_BITS-1:0] w_cursor_nxt;
  song_e                 w_song_nxt;

  assign w_key_raw[KEY_UP]   = key_up;
  assign w_key_raw[KEY_DOWN] = key_down;
  assign w_key_raw[KEY_OK]   = key_ok;
  assign w_key_raw[KEY_BACK] = key_back;

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_raw  (w_key_raw[i]),
        .key_pulse(w_pulse[i])
      );
    end
  endgenerate

  // Only the highest-priority key of a simultaneous group acts.
  assign w_back = w_pulse[KEY_BACK];
  assign w_ok   = w_pulse[KEY_OK] && !w_back;
  assign w_up   = w_pulse[KEY_UP] && !w_pulse[KEY_OK] && !w_back;
  assign w_down = w_pulse[KEY_DOWN] && !w_pulse[KEY_UP] && !w_pulse[KEY_OK] && !w_back;

`ifdef IDLE_TIMEOUT_EN
  logic [31:0] r_idle;
  logic        w_idle_mode;

  assign w_idle_mode = (r_state == FREE_MODE) || (r_state == SET_MODE);
  assign w_timeout   = w_idle_mode && !(|w_pulse) && (r_idle == IDLE_CYC - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_idle_mode || (|w_pulse) || (w_state_nxt != r_state)) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 32'd1;
    end
  end
`else
  // No idle timer in this build; the parameter only keeps the interface uniform.
  assign w_timeout = 1'b0 & (IDLE_CYC == 32'd0);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_song_nxt   = r_song;
    case (r_state)
      MENU_MODE: begin
        if (w_ok) begin
          w_state_nxt = mode_e'(r_cursor);
        end else if (w_up) begin
          w_cursor_nxt = cursor_step(r_cursor, 1'b1);
        end else if (w_down) begin
          w_cursor_nxt = cursor_step(r_cursor, 1'b0);
        end
      end
      FREE_MODE, SET_MODE: begin
        if (w_back || w_timeout) begin
          w_state_nxt  = MENU_MODE;
          w_cursor_nxt = r_state;
        end
      end
      AUTO_MODE, STDY_MODE, PLAY_MODE: begin
        if (w_back) begin
          w_state_nxt  = MENU_MODE;
          w_cursor_nxt = r_state;
        end else if ((w_up || w_down) && !busy) begin
          w_song_nxt = (r_song == LITTLE_STAR) ? TWO_TIGERS : LITTLE_STAR;
        end
      end
      default: begin
        w_state_nxt = MENU_MODE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MENU_MODE;
      r_cursor   <= FREE_MODE;
      r_song     <= LITTLE_STAR;
      r_mode_chg <= 1'b0;
      r_song_chg <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cursor   <= w_cursor_nxt;
      r_song     <= w_song_nxt;
      r_mode_chg <= (w_state_nxt != r_state);
      r_song_chg <= (w_song_nxt != r_song);
    end
  end

  assign state    = r_state;
  assign cursor   = r_cursor;
  assign song     = r_song;
  assign mode_chg = r_mode_chg;
  assign song_chg = r_song_chg;

endmodule

`default_nettype wire
